des_key_sched: RTL
==================

// Module: des_key_sched
// PURPOSE
//   Iterative DES key-schedule stage that feeds the encrypt/decrypt round datapath.
//   Accepts one 64-bit key and a direction flag, applies PC-1, and streams the 16
//   48-bit round subkeys, one per handshake. Encrypt order is K1..K16; decrypt order is K16..K1.
//   Replaces the flat 56-bit key wire with a registered, back-pressurable subkey stream.
// PARAMETERS
//   KEY_W     64  input key width, parity bits included (fixed by DES)
//   SUBKEY_W  48  round subkey width after PC-2
//   ROUNDS    16  subkeys emitted per key; the shift table is indexed 0..ROUNDS-1
// PORTS
//   clk         in   1         rising-edge clock
//   rst_n       in   1         asynchronous active-low reset
//   key_valid   in   1         key and dec are valid
//   key_ready   out  1         block can accept a key (IDLE)
//   key         in   KEY_W     DES key; bit 63 = DES bit 1
//   dec         in   1         0 = encrypt order, 1 = decrypt order
//   sk_valid    out  1         subkey and sk_round are valid
//   sk_ready    in   1         consumer takes the subkey
//   subkey      out  SUBKEY_W  PC-2(C,D) of the current round
//   sk_round    out  4         index of the subkey in emission order, 0..15
//   sk_last     out  1         high with the 16th subkey
//   key_err     out  1         one-cycle pulse: key rejected (only with DES_PARITY_CHECK_EN)
// BEHAVIOUR
//   Reset: all outputs 0 except key_ready=1; state IDLE; C, D, round counter and dir cleared.
//     Reset mid-stream aborts the key immediately with no further subkeys.
//   FSM, two states:
//     IDLE: key_ready=1, sk_valid=0.
//       On key_valid&key_ready, load {C,D}=PC1(key) and latch dir.
//       Encrypt: load {C,D} already left-rotated by SHIFT[0]=1, giving C1D1.
//       Decrypt: load unrotated, because C0D0 equals C16D16.
//       Clear the round counter and go to GEN.
//     GEN: sk_valid=1; subkey=PC2(C,D) is driven combinationally from the registers.
//       When sk_valid&sk_ready and round!=15: round++.
//         Encrypt: rotate C and D left by SHIFT[round+1].
//         Decrypt: rotate C and D right by SHIFT[15-round].
//       When sk_valid&sk_ready and round==15: return to IDLE.
//       If sk_ready is low, C, D, round and subkey hold stable.
//   Latency: first subkey is valid the cycle after key acceptance.
//     With sk_ready held high, 16 consecutive cycles of subkeys.
//     A new key is accepted no earlier than 1 cycle after sk_last is consumed.
//   sk_last = GEN && round==15.
//   Rotations are 28-bit circular per half, 1 or 2 positions per the DES schedule:
//     SHIFT = {1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1}.
//   key_valid during GEN is ignored (key_ready=0); the upstream block holds its key.
// CONFIGURATION
//   DES_PARITY_CHECK_EN defined:
//     On acceptance, each key byte must have odd parity.
//     Any failing byte: stay in IDLE, emit no subkeys, pulse key_err for exactly 1 cycle.
//   DES_PARITY_CHECK_EN undefined:
//     Parity bits are ignored (dropped by PC-1) and key_err is tied to 0.
// STRUCTURE
//   Package des_pkg holds:
//     - PC1 table (56 entries) and PC2 table (48 entries) as localparam arrays
//     - the SHIFT schedule
//     - an FSM state enum {IDLE, GEN}
//     - width constants (56, 28, 48)
//   One sub-module, des_pc2: a purely combinational 56->48 permutation, shared with the
//     round datapath if needed.
//   PC-1 is an inline function applied at load.
// TESTING
//   1. Encrypt, key=0x133457799BBCDFF1, sk_ready=1:
//      round0 subkey=0x1B02EFFC7072; round15 subkey=0xCB3D8B0E17F5 with sk_last=1.
//   2. Same key, dec=1:
//      round0 subkey=0xCB3D8B0E17F5; round15 subkey=0x1B02EFFC7072.
//      All 16 subkeys are the encrypt sequence reversed.
//   3. Backpressure: toggle sk_ready randomly.
//      subkey/sk_round stay stable while stalled; exactly 16 transfers; the sequence matches test 1.
//   4. Reset asserted at round 7:
//      sk_valid=0 and key_ready=1 asynchronously.
//      The next key yields the full 16-subkey sequence from round 0.
//   5. key_valid held high during GEN with a different key:
//      it is ignored; after sk_last, the new key is accepted and its sequence emitted.
//   6. With DES_PARITY_CHECK_EN, key=0x133457799BBCDFF0 (last byte even parity):
//      key_err pulses 1 cycle, sk_valid stays 0.
//      Without the macro, the same key gives the test-1 subkeys.

Source files
------------

// File: rtl/des_pkg.sv
// des_pkg: DES key-schedule tables, shift schedule, FSM state and widths
package des_pkg;
   localparam int CD_W   = 56;
   localparam int HALF_W = 28;
   localparam int SK_W   = 48;
   typedef enum logic {IDLE, GEN} state_t;
   localparam int SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
   // Entries are DES bit numbers, 1 = MSB of the source word
   localparam int PC1 [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
   localparam int PC2 [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
   function automatic logic [HALF_W-1:0] rot28(input logic [HALF_W-1:0] x, input logic right, input int s);
      return right ? (s == 2 ? {x[1:0], x[27:2]} : {x[0], x[27:1]})
                   : (s == 2 ? {x[25:0], x[27:26]} : {x[26:0], x[27]});
   endfunction
endpackage

// File: rtl/des_pc2.sv
// des_pc2: combinational DES PC-2 permutation, 56-bit {C,D} to 48-bit subkey
module des_pc2
   import des_pkg::*;
(
   input  logic [CD_W-1:0] cd,
   output logic [SK_W-1:0] sk
);
   always_comb begin
      sk = '0;
      for (int i = 0; i < SK_W; i++) sk[SK_W-1-i] = cd[CD_W-PC2[i]];
   end
endmodule

// File: rtl/des_key_sched.sv
// des_key_sched: iterative DES key schedule streaming 16 subkeys per key.
// Define DES_PARITY_CHECK_EN to reject keys with an even-parity byte via key_err.
module des_key_sched
   import des_pkg::*;
#(
   parameter int KEY_W    = 64,
   parameter int SUBKEY_W = 48,
   parameter int ROUNDS   = 16
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                key_valid,
   output logic                key_ready,
   input  logic [KEY_W-1:0]    key,
   input  logic                dec,
   output logic                sk_valid,
   input  logic                sk_ready,
   output logic [SUBKEY_W-1:0] subkey,
   output logic [3:0]          sk_round,
   output logic                sk_last,
   output logic                key_err
);
   state_t state, state_nx;
   logic [CD_W-1:0] cd, cd0;
   logic [3:0] round, si;
   logic dir, par_ok, acc, xfer;
   function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] k);
      pc1 = '0;
      for (int i = 0; i < CD_W; i++) pc1[CD_W-1-i] = k[KEY_W-PC1[i]];
   endfunction
`ifdef DES_PARITY_CHECK_EN
   always_comb begin
      par_ok = 1'b1;
      for (int i = 0; i < 8; i++) par_ok &= ^key[8*i +: 8];
   end
`else
   assign par_ok = 1'b1;
`endif
   assign key_ready = state == IDLE;
   assign sk_valid  = state == GEN;
   assign sk_round  = round;
   assign sk_last   = sk_valid && round == 4'(ROUNDS-1);
   assign acc       = key_valid & key_ready & par_ok;
   assign xfer      = sk_valid & sk_ready;
   assign cd0       = pc1(key);
   // Decrypt walks the schedule backwards: undo the shift that produced the current round
   assign si        = dir ? 4'd15 - round : round + 4'd1;
   always_comb state_nx = acc ? GEN : (xfer && sk_last) ? IDLE : state;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cd      <= '0;
         round   <= '0;
         dir     <= 1'b0;
         key_err <= 1'b0;
      end else begin
         key_err <= key_valid & key_ready & ~par_ok;
         if (acc) begin
            cd    <= dec ? cd0 : {rot28(cd0[55:28], 1'b0, SHIFT[0]), rot28(cd0[27:0], 1'b0, SHIFT[0])};
            dir   <= dec;
            round <= '0;
         end else if (xfer && !sk_last) begin
            cd    <= {rot28(cd[55:28], dir, SHIFT[si]), rot28(cd[27:0], dir, SHIFT[si])};
            round <= round + 4'd1;
         end
      end
   des_pc2 u_pc2 (.cd(cd), .sk(subkey));
endmodule
